// File: rtl/snn_simple_core_pkg.sv
// Fixed-point constants and arithmetic helpers for the two-neuron LIF core.
// Q6.10 signed values; products truncate via arithmetic shift, sums saturate.
package snn_simple_core_pkg;

   localparam int W  = 16;
   localparam int Q  = 10;
   localparam int WW = 2*W;

   typedef logic signed [W-1:0]  fx_t;
   typedef logic signed [WW-1:0] acc_t;

   // x*2^Q truncated toward zero
   localparam fx_t FX_ONE      = 16'sd1024;
   localparam fx_t G_DECAY_E   = 16'sd942;
   localparam fx_t G_DECAY_I   = 16'sd901;
   localparam fx_t LEAK        = 16'sd51;
   localparam fx_t V_REST      = 16'sd0;
   localparam fx_t V_RESET     = 16'sd0;
   localparam fx_t V_TH        = 16'sd1024;
   localparam fx_t V_MIN       = -16'sd1024;
   localparam fx_t W_INIT      = 16'sd512;
   localparam fx_t W_MAX       = 16'sd1024;
   localparam fx_t W_LAT_E     = 16'sd307;
   localparam fx_t W_LAT_I     = 16'sd409;
   localparam fx_t A_PLUS      = 16'sd10;
   localparam fx_t A_MINUS     = 16'sd12;
   localparam fx_t TRACE_DECAY = 16'sd921;

   localparam acc_t SAT_MAX = 32'sd32767;
   localparam acc_t SAT_MIN = -32'sd32768;

   function automatic acc_t ext(input fx_t a);
      return WW'(a);
   endfunction

   function automatic acc_t mulq(input fx_t a, input fx_t b);
      acc_t p;
      p = ext(a) * ext(b);
      return p >>> Q;
   endfunction

   function automatic fx_t sat(input acc_t x);
      if (x > SAT_MAX) return 16'sh7FFF;
      if (x < SAT_MIN) return 16'sh8000;
      return x[W-1:0];
   endfunction

   function automatic acc_t gate(input logic en, input fx_t a);
      return en ? ext(a) : '0;
   endfunction

   function automatic int dly_clamp(input logic [7:0] d);
      if (d == 8'd0) return 1;
      if (d > 8'd16) return 16;
      return int'(d);
   endfunction

endpackage

// File: rtl/snn_layer.sv
// Weight array, conductances and the two LIF neurons of snn_simple_core.
// SNN_STDP_EN enables pre/post traces and on-line weight learning.
module snn_layer
   import snn_simple_core_pkg::*;
#(
   parameter int REFR_TICKS = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in0_spike,
   input  logic in1_spike,
   input  logic d01,
   input  logic d10,
   output logic n0_spike,
   output logic n1_spike,
   output fx_t  n0_vmem,
   output fx_t  n1_vmem
);

   localparam logic [7:0] REFR_W = 8'(REFR_TICKS);

   fx_t        weights [0:1][0:1];
   fx_t        ge [0:1], gi [0:1], v [0:1];
   fx_t        ge_nx [0:1], gi_nx [0:1], vn [0:1];
   logic [7:0] refr [0:1];
   logic [1:0] spike, pre;

   assign pre      = {in1_spike, in0_spike};
   assign n0_spike = spike[0];
   assign n1_spike = spike[1];
   assign n0_vmem  = v[0];
   assign n1_vmem  = v[1];

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         ge_nx[i] = sat(mulq(ge[i], G_DECAY_E) + gate(pre[0], weights[i][0])
                        + gate(pre[1], weights[i][1]) + gate((i == 1) && d01, W_LAT_E));
         gi_nx[i] = sat(mulq(gi[i], G_DECAY_I) + gate((i == 0) && d10, W_LAT_I));
         vn[i]    = sat(ext(v[i]) + mulq(V_REST - v[i], LEAK) + ext(ge[i]) - ext(gi[i]));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spike <= '0;
         for (int i = 0; i < 2; i++) begin
            ge[i]   <= '0;
            gi[i]   <= '0;
            v[i]    <= V_RESET;
            refr[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            ge[i] <= ge_nx[i];
            gi[i] <= gi_nx[i];
            if (refr[i] != 8'd0) begin
               v[i]     <= V_RESET;
               refr[i]  <= refr[i] - 8'd1;
               spike[i] <= 1'b0;
            end else if (vn[i] >= V_TH) begin
               v[i]     <= V_RESET;
               refr[i]  <= REFR_W;
               spike[i] <= 1'b1;
            end else begin
               v[i]     <= (vn[i] < V_MIN) ? V_MIN : vn[i];
               refr[i]  <= 8'd0;
               spike[i] <= 1'b0;
            end
         end
      end
   end

`ifdef SNN_STDP_EN
   fx_t  x [0:1], y [0:1];
   fx_t  w_nx [0:1][0:1];
   acc_t s;

   // Learning uses the traces as they stood before this edge's update
   always_comb begin
      s = '0;
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 2; j++) begin
            s = ext(weights[i][j]);
            if (spike[i]) s = s + mulq(A_PLUS, x[j]);
            if (pre[j])   s = s - mulq(A_MINUS, y[i]);
            if (s < 0)                w_nx[i][j] = '0;
            else if (s > ext(W_MAX))  w_nx[i][j] = W_MAX;
            else                      w_nx[i][j] = s[W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            x[i] <= '0;
            y[i] <= '0;
            for (int j = 0; j < 2; j++) weights[i][j] <= W_INIT;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            x[i] <= pre[i]   ? FX_ONE : sat(mulq(x[i], TRACE_DECAY));
            y[i] <= spike[i] ? FX_ONE : sat(mulq(y[i], TRACE_DECAY));
            for (int j = 0; j < 2; j++) weights[i][j] <= w_nx[i][j];
         end
      end
   end
`else
   always_comb begin
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) weights[i][j] = W_INIT;
   end
`endif

endmodule

// File: rtl/snn_simple_core.sv
// Two-input, two-neuron LIF network: lateral delay lines around snn_layer.
// Define SNN_STDP_EN to enable STDP learning inside the layer.
module snn_simple_core
   import snn_simple_core_pkg::*;
#(
   parameter int         REFR_TICKS = 4,
   parameter logic [7:0] DELAY01    = 8'd3,
   parameter logic [7:0] DELAY10    = 8'd5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in0_spike,
   input  logic in1_spike,
   output logic n0_spike,
   output logic n1_spike,
   output fx_t  n0_vmem,
   output fx_t  n1_vmem
);

   localparam int          D01   = dly_clamp(DELAY01);
   localparam int          D10   = dly_clamp(DELAY10);
   localparam logic [15:0] SEL01 = 16'd1 << (D01 - 1);
   localparam logic [15:0] SEL10 = 16'd1 << (D10 - 1);

   // The live spike output is tap 0, so 15 flops give a 16-deep line
   logic [14:0] dl01, dl10;
   logic        d01, d10;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dl01 <= '0;
         dl10 <= '0;
      end else begin
         dl01 <= {dl01[13:0], n0_spike};
         dl10 <= {dl10[13:0], n1_spike};
      end
   end

   assign d01 = |({dl01, n0_spike} & SEL01);
   assign d10 = |({dl10, n1_spike} & SEL10);

   snn_layer #(.REFR_TICKS(REFR_TICKS)) u_layer (
      .clk       (clk),
      .rst_n     (rst_n),
      .in0_spike (in0_spike),
      .in1_spike (in1_spike),
      .d01       (d01),
      .d10       (d10),
      .n0_spike  (n0_spike),
      .n1_spike  (n1_spike),
      .n0_vmem   (n0_vmem),
      .n1_vmem   (n1_vmem)
   );

endmodule

// File: tb/tb_snn_simple_core.sv
// Self-checking bench for snn_simple_core against a cycle-level LIF/STDP model.
// Honours SNN_STDP_EN the same way the design does.
module tb_snn_simple_core;

   logic clk = 1'b0;
   logic rst_n;
   logic in0_spike, in1_spike;
   logic n0_spike, n1_spike;
   logic signed [15:0] n0_vmem, n1_vmem;

   int checks = 0;
   int failures = 0;

   localparam int D01 = 3;
   localparam int D10 = 5;

   always #5 clk = ~clk;

   snn_simple_core #(.REFR_TICKS(4), .DELAY01(8'd3), .DELAY10(8'd5)) dut (
      .clk(clk), .rst_n(rst_n), .in0_spike(in0_spike), .in1_spike(in1_spike),
      .n0_spike(n0_spike), .n1_spike(n1_spike), .n0_vmem(n0_vmem), .n1_vmem(n1_vmem)
   );

   // ---------------- reference model (integer arithmetic from the rules) -------------
   int m_ge[2], m_gi[2], m_v[2], m_refr[2], m_spk[2], m_x[2], m_y[2];
   int m_w[2][2];
   int hist0[$], hist1[$];

   function automatic int qmul(input int a, input int b);
      return int'($floor(real'(a * b) / 1024.0));
   endfunction

   function automatic int sat16(input int a);
      return (a > 32767) ? 32767 : (a < -32768) ? -32768 : a;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_ge[i] = 0; m_gi[i] = 0; m_v[i] = 0; m_refr[i] = 0; m_spk[i] = 0;
         m_x[i] = 0; m_y[i] = 0;
         for (int j = 0; j < 2; j++) m_w[i][j] = 512;
      end
      hist0.delete(); hist1.delete();
   endtask

   task automatic model_step(input int a, input int b);
      int pre[2];
      int nge[2], ngi[2], nv[2], nr[2], ns[2], nx[2], ny[2];
      int nw[2][2];
      int d01, d10, vn, t;
      pre[0] = a; pre[1] = b;
      d01 = (hist0.size() >= D01) ? hist0[D01-1] : 0;
      d10 = (hist1.size() >= D10) ? hist1[D10-1] : 0;
      for (int i = 0; i < 2; i++) begin
         nge[i] = sat16(qmul(m_ge[i], 942) + (pre[0] ? m_w[i][0] : 0) + (pre[1] ? m_w[i][1] : 0)
                        + ((i == 1 && d01 != 0) ? 307 : 0));
         ngi[i] = sat16(qmul(m_gi[i], 901) + ((i == 0 && d10 != 0) ? 409 : 0));
         if (m_refr[i] > 0) begin
            nv[i] = 0; nr[i] = m_refr[i] - 1; ns[i] = 0;
         end else begin
            vn = sat16(m_v[i] + qmul(0 - m_v[i], 51) + m_ge[i] - m_gi[i]);
            if (vn >= 1024) begin nv[i] = 0; nr[i] = 4; ns[i] = 1; end
            else begin nv[i] = (vn < -1024) ? -1024 : vn; nr[i] = 0; ns[i] = 0; end
         end
         nx[i] = pre[i] ? 1024 : qmul(m_x[i], 921);
         ny[i] = m_spk[i] ? 1024 : qmul(m_y[i], 921);
         for (int j = 0; j < 2; j++) begin
            t = m_w[i][j];
`ifdef SNN_STDP_EN
            if (m_spk[i] != 0) t = t + qmul(10, m_x[j]);
            if (pre[j] != 0)   t = t - qmul(12, m_y[i]);
            t = (t < 0) ? 0 : (t > 1024) ? 1024 : t;
`endif
            nw[i][j] = t;
         end
      end
      m_ge = nge; m_gi = ngi; m_v = nv; m_refr = nr; m_spk = ns; m_x = nx; m_y = ny; m_w = nw;
      hist0.push_front(ns[0]); hist1.push_front(ns[1]);
      if (hist0.size() > 16) void'(hist0.pop_back());
      if (hist1.size() > 16) void'(hist1.pop_back());
   endtask

   // ---------------- DUT access and stimulus -----------------------------------------
   function automatic int rd_w(input int i, input int j);
      case ({i[0], j[0]})
         2'b00:   return dut.u_layer.weights[0][0];
         2'b01:   return dut.u_layer.weights[0][1];
         2'b10:   return dut.u_layer.weights[1][0];
         default: return dut.u_layer.weights[1][1];
      endcase
   endfunction

   function automatic int rd_ge(input int i);
      return i[0] ? dut.u_layer.ge[1] : dut.u_layer.ge[0];
   endfunction

   function automatic int rd_gi(input int i);
      return i[0] ? dut.u_layer.gi[1] : dut.u_layer.gi[0];
   endfunction

   task automatic step(input int a, input int b);
      in0_spike = a[0]; in1_spike = b[0];
      @(posedge clk); #1;
      model_step(a, b);
   endtask

   task automatic do_reset();
      in0_spike = 1'b0; in1_spike = 1'b0; rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   // ---------------- scenarios -------------------------------------------------------
   task automatic test_reset();
      int w;
      do_reset();
      checks++;
      if (n0_vmem !== 16'sd0 || n1_vmem !== 16'sd0 || n0_spike !== 1'b0 || n1_spike !== 1'b0) begin
         failures++;
         $display("FAIL reset_out: got v0=%0d v1=%0d s0=%b s1=%b want all 0", n0_vmem, n1_vmem, n0_spike, n1_spike);
      end
      for (int c = 0; c < 100; c++) begin
         step(0, 0);
         checks++;
         if (n0_vmem !== 16'sd0 || n1_vmem !== 16'sd0 || n0_spike !== 1'b0 || n1_spike !== 1'b0) begin
            failures++;
            $display("FAIL idle_out c=%0d: got v0=%0d v1=%0d s0=%b s1=%b want all 0", c, n0_vmem, n1_vmem, n0_spike, n1_spike);
         end
         for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
               w = rd_w(i, j);
               checks++;
               if (w !== 512) begin
                  failures++;
                  $display("FAIL idle_weight[%0d][%0d] c=%0d: got %0d want 512", i, j, c, w);
               end
            end
      end
   endtask

   task automatic test_single_pulse();
      int g0, g1;
      do_reset();
      step(1, 0);
      g0 = rd_ge(0); g1 = rd_ge(1);
      checks++;
      if (g0 !== 512 || g1 !== 512) begin
         failures++;
         $display("FAIL pulse_ge: got ge0=%0d ge1=%0d want 512 512", g0, g1);
      end
      checks++;
      if (n0_vmem !== 16'sd0) begin
         failures++;
         $display("FAIL pulse_v_early: got %0d want 0", n0_vmem);
      end
      step(0, 0);
      g0 = rd_ge(0);
      checks++;
      if (n0_vmem !== 16'sd512) begin
         failures++;
         $display("FAIL pulse_v: got %0d want 512", n0_vmem);
      end
      checks++;
      if (g0 !== 471) begin
         failures++;
         $display("FAIL pulse_decay: got %0d want 471", g0);
      end
      step(0, 0);
      checks++;
      if ($signed(n0_vmem) !== m_v[0]) begin
         failures++;
         $display("FAIL pulse_v_next: got %0d want %0d", n0_vmem, m_v[0]);
      end
   endtask

   task automatic test_refractory();
      int first;
      do_reset();
      first = -1;
      for (int c = 1; c <= 3 && first < 0; c++) begin
         step(1, 1);
         if (n0_spike === 1'b1) first = c;
      end
      checks++;
      if (first < 0 || n0_vmem !== 16'sd0) begin
         failures++;
         $display("FAIL fire_within_3: got first=%0d v0=%0d want spike with v0=0", first, n0_vmem);
      end
      for (int k = 0; k < 4; k++) begin
         step(1, 1);
         checks++;
         if (n0_spike !== 1'b0 || n0_vmem !== 16'sd0) begin
            failures++;
            $display("FAIL refractory k=%0d: got s0=%b v0=%0d want 0 0", k, n0_spike, n0_vmem);
         end
      end
      step(1, 1);
      checks++;
      if (n0_spike !== 1'b1 || m_spk[0] != 1) begin
         failures++;
         $display("FAIL refire: got s0=%b model=%0d want 1", n0_spike, m_spk[0]);
      end
   endtask

   task automatic test_lateral();
      int g;
      do_reset();
      step(1, 1);
      step(0, 0);
      checks++;
      if (n0_spike !== 1'b1 || n1_spike !== 1'b1) begin
         failures++;
         $display("FAIL lat_spike: got s0=%b s1=%b want 1 1", n0_spike, n1_spike);
      end
      step(0, 0); step(0, 0);
      g = rd_ge(1);
      checks++;
      if (g !== 796) begin
         failures++;
         $display("FAIL lat_e_early: got %0d want 796", g);
      end
      step(0, 0);
      g = rd_ge(1);
      checks++;
      if (g !== 1039 || g !== m_ge[1]) begin
         failures++;
         $display("FAIL lat_e: got %0d want 1039 (model %0d)", g, m_ge[1]);
      end
      step(0, 0);
      g = rd_gi(0);
      checks++;
      if (g !== 0) begin
         failures++;
         $display("FAIL lat_i_early: got %0d want 0", g);
      end
      step(0, 0);
      g = rd_gi(0);
      checks++;
      if (g !== 409) begin
         failures++;
         $display("FAIL lat_i: got %0d want 409", g);
      end
      step(0, 0);
      g = rd_gi(0);
      checks++;
      if (g !== 359) begin
         failures++;
         $display("FAIL lat_i_decay: got %0d want 359", g);
      end
   endtask

   task automatic test_stdp();
      int w00, w01, exp00;
`ifdef SNN_STDP_EN
      exp00 = 520;
`else
      exp00 = 512;
`endif
      do_reset();
      step(1, 0); step(1, 0); step(0, 0);
      checks++;
      if (n0_spike !== 1'b1) begin
         failures++;
         $display("FAIL stdp_post: got s0=%b want 1", n0_spike);
      end
      step(0, 0);
      w00 = rd_w(0, 0); w01 = rd_w(0, 1);
      checks++;
      if (w00 !== exp00 || w00 < 0 || w00 > 1024) begin
         failures++;
         $display("FAIL stdp_w00: got %0d want %0d", w00, exp00);
      end
      checks++;
      if (w01 !== 512) begin
         failures++;
         $display("FAIL stdp_w01: got %0d want 512", w01);
      end
   endtask

   task automatic test_random();
      int a, b, g0, gi0, w;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         a = ($urandom_range(0, 99) < 35) ? 1 : 0;
         b = ($urandom_range(0, 99) < 35) ? 1 : 0;
         step(a, b);
         g0 = rd_ge(0); gi0 = rd_gi(0);
         checks++;
         if (n0_spike !== m_spk[0][0] || n1_spike !== m_spk[1][0] ||
             $signed(n0_vmem) !== m_v[0] || $signed(n1_vmem) !== m_v[1]) begin
            failures++;
            $display("FAIL rand_out c=%0d: got s=%b%b v0=%0d v1=%0d want s=%0d%0d v0=%0d v1=%0d",
                     c, n1_spike, n0_spike, n0_vmem, n1_vmem, m_spk[1], m_spk[0], m_v[0], m_v[1]);
         end
         checks++;
         if (g0 !== m_ge[0] || gi0 !== m_gi[0]) begin
            failures++;
            $display("FAIL rand_cond c=%0d: got ge0=%0d gi0=%0d want %0d %0d", c, g0, gi0, m_ge[0], m_gi[0]);
         end
         for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
               w = rd_w(i, j);
               checks++;
               if (w !== m_w[i][j] || w < 0 || w > 1024) begin
                  failures++;
                  $display("FAIL rand_w[%0d][%0d] c=%0d: got %0d want %0d", i, j, c, w, m_w[i][j]);
               end
            end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_pulse();
      test_refractory();
      test_lateral();
      test_stdp();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
